// File: rtl/time_set_ctrl.sv
// time_set_ctrl: clock/time-setting controller with RUN, SET_HOUR and SET_MIN modes,
// button edge detection, hold-to-repeat increment, set-mode timeout and blinking BCD display.
module time_set_ctrl #(
  parameter logic [15:0] HOLD_CYCLES   = 16'd1000,
  parameter logic [15:0] REPEAT_CYCLES = 16'd250,
  parameter logic [5:0]  TIMEOUT_TICKS = 6'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        disp_sel,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [1:0]  mode,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  mode_e       state, nxt_state;
  logic        mode_q, inc_q, armed;
  logic        blink_phase, nxt_blink;
  logic [5:0]  tout_cnt, nxt_tout;
  logic [15:0] hold_cnt, nxt_hold;
  logic        repeating, nxt_repeating;
  logic [4:0]  nxt_hours;
  logic [5:0]  nxt_min, nxt_sec;
  logic [5:0]  disp_hi, disp_lo;
  logic [15:0] nxt_digits;
  logic [3:0]  nxt_blank;
  logic        mode_edge, inc_edge, rep_fire, set_mode, inc_req;

  // Edges are masked for the first cycle out of reset so a button already held is not an edge
  assign mode_edge = armed & btn_mode & ~mode_q;
  assign inc_edge  = armed & btn_inc & ~inc_q;
  assign set_mode  = (state != RUN);
  assign rep_fire  = set_mode & btn_inc & (hold_cnt != 16'd0) &
                     ((!repeating && hold_cnt == HOLD_CYCLES) ||
                      (repeating && hold_cnt == REPEAT_CYCLES));
  assign inc_req   = set_mode & (inc_edge | rep_fire);
  assign mode      = state;

  // Next-state computation for mode, time fields, hold/repeat and timeout counters
  always_comb begin
    nxt_state     = state;
    nxt_hours     = hours;
    nxt_min       = minutes;
    nxt_sec       = seconds;
    nxt_tout      = tout_cnt;
    nxt_hold      = hold_cnt;
    nxt_repeating = repeating;

    if (!set_mode || !btn_inc) begin
      nxt_hold      = 16'd0;
      nxt_repeating = 1'b0;
    end else if (inc_edge) begin
      nxt_hold      = 16'd1;
      nxt_repeating = 1'b0;
    end else if (rep_fire) begin
      nxt_hold      = 16'd1;
      nxt_repeating = 1'b1;
    end else if (hold_cnt != 16'd0) begin
      nxt_hold = hold_cnt + 16'd1;
    end

    if (!set_mode && tick) begin
      if (seconds == 6'd59) begin
        nxt_sec = 6'd0;
        if (minutes == 6'd59) begin
          nxt_min   = 6'd0;
          nxt_hours = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          nxt_min = minutes + 6'd1;
        end
      end else begin
        nxt_sec = seconds + 6'd1;
      end
    end

    if (mode_edge) begin
      nxt_hold      = 16'd0;
      nxt_repeating = 1'b0;
      nxt_tout      = 6'd0;
      case (state)
        RUN:      nxt_state = SET_HOUR;
        SET_HOUR: nxt_state = SET_MIN;
        default: begin
          nxt_state = RUN;
          nxt_sec   = 6'd0;
        end
      endcase
    end else if (!set_mode) begin
      nxt_tout = 6'd0;
    end else if (inc_req) begin
      nxt_tout = 6'd0;
      if (state == SET_HOUR) nxt_hours = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      else                   nxt_min   = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end else if (tick) begin
      if (tout_cnt == TIMEOUT_TICKS - 6'd1) begin
        nxt_tout  = 6'd0;
        nxt_state = RUN;
        if (state == SET_MIN) nxt_sec = 6'd0;
      end else begin
        nxt_tout = tout_cnt + 6'd1;
      end
    end

    if (nxt_state == RUN)      nxt_blink = 1'b0;
    else if (set_mode && tick) nxt_blink = ~blink_phase;
    else                       nxt_blink = blink_phase;
  end

  // Display digits and blank mask derived from the next-cycle state
  always_comb begin
    if (nxt_state == RUN && disp_sel) begin
      disp_hi = nxt_min;
      disp_lo = nxt_sec;
    end else begin
      disp_hi = {1'b0, nxt_hours};
      disp_lo = nxt_min;
    end
    nxt_digits = {4'(disp_hi / 6'd10), 4'(disp_hi % 6'd10),
                  4'(disp_lo / 6'd10), 4'(disp_lo % 6'd10)};
    nxt_blank = 4'b0000;
    if (nxt_blink) begin
      if (nxt_state == SET_HOUR)     nxt_blank = 4'b1100;
      else if (nxt_state == SET_MIN) nxt_blank = 4'b0011;
    end
  end

  // State, time and display registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= RUN;
      hours       <= 5'd0;
      minutes     <= 6'd0;
      seconds     <= 6'd0;
      blink_phase <= 1'b0;
      tout_cnt    <= 6'd0;
      hold_cnt    <= 16'd0;
      repeating   <= 1'b0;
      mode_q      <= 1'b0;
      inc_q       <= 1'b0;
      armed       <= 1'b0;
      digits      <= 16'h0000;
      blank       <= 4'b0000;
    end else begin
      state       <= nxt_state;
      hours       <= nxt_hours;
      minutes     <= nxt_min;
      seconds     <= nxt_sec;
      blink_phase <= nxt_blink;
      tout_cnt    <= nxt_tout;
      hold_cnt    <= nxt_hold;
      repeating   <= nxt_repeating;
      mode_q      <= btn_mode;
      inc_q       <= btn_inc;
      armed       <= 1'b1;
      digits      <= nxt_digits;
      blank       <= nxt_blank;
    end
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16'd1000: cycles btn_inc must stay high before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 16'd250: cycles between auto-repeat increments.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 6'd30: ticks without a button edge before set mode exits.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port tick  input  1  one-cycle 1 Hz enable pulse.
REQ-007 SHALL have port btn_mode  input  1  mode button, already synchronized and debounced, level.
REQ-008 SHALL have port btn_inc  input  1  increment button, already synchronized and debounced, level.
REQ-009 SHALL have port disp_sel  input  1  RUN view select: 0 = HH:MM, 1 = MM:SS.
REQ-010 SHALL have port digits  output  16  four BCD digits, [15:12] most significant.
REQ-011 SHALL have port blank  output  4  per-digit blank mask, bit3 = digits[15:12].
REQ-012 SHALL have port mode  output  2  state: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
REQ-013 SHALL have port hours  output  5  binary 0-23; minutes output 6 binary 0-59; seconds output 6 binary 0-59.

Function
REQ-014 SHALL detect rising edges of btn_mode and btn_inc using registered previous values; edge valid one cycle.
REQ-015 SHALL implement FSM RUN -> SET_HOUR -> SET_MIN -> RUN, advancing one state per btn_mode edge.
REQ-016 SHALL, in RUN on tick, increment seconds; 59->0 carries minutes; minutes 59->0 carries hours; hours 23->0.
REQ-017 SHALL hold hours/minutes/seconds unchanged on tick in SET_HOUR and SET_MIN.
REQ-018 SHALL, on btn_inc edge in SET_HOUR, increment hours with wrap 23->0, no carry into other fields.
REQ-019 SHALL, on btn_inc edge in SET_MIN, increment minutes with wrap 59->0, no carry into hours.
REQ-020 SHALL ignore btn_inc in RUN.
REQ-021 SHALL auto-repeat: btn_inc held high HOLD_CYCLES cycles after its edge produces one increment, then one every REPEAT_CYCLES cycles while held; release stops repeat and clears hold counter.
REQ-022 SHALL give btn_mode edge priority over a same-cycle btn_inc edge or repeat increment; that increment is discarded and hold counter cleared.
REQ-023 SHALL clear seconds to 0 on transition SET_MIN -> RUN (by btn_mode edge or timeout).
REQ-024 SHALL count ticks in set modes, clear count on any button edge or repeat increment, and enter RUN when count reaches TIMEOUT_TICKS.
REQ-025 SHALL toggle blink_phase on every tick in set modes and force blink_phase to 0 in RUN.
REQ-026 SHALL drive digits as HH:MM BCD in set modes and in RUN with disp_sel=0; MM:SS BCD in RUN with disp_sel=1; tens = value/10, units = value%10.
REQ-027 SHALL drive blank = 4'b1100 in SET_HOUR and 4'b0011 in SET_MIN when blink_phase=1; otherwise 4'b0000.
REQ-028 SHALL make field updates visible on hours/minutes/seconds/digits one cycle after the causing edge or tick.
REQ-029 SHALL treat a tick coinciding with the RUN-entry cycle as belonging to the old state (no increment).

Reset
REQ-030 SHALL, while reset=0 at a clock edge, set mode=RUN, hours=0, minutes=0, seconds=0, blink_phase=0, timeout and hold counters=0, edge registers=0.
REQ-031 SHALL produce digits=16'h0000 and blank=4'b0000 one cycle after reset; reset mid-set-mode returns to RUN with time cleared.
REQ-032 SHALL not treat a button already high when reset releases as an edge.

Verification
REQ-033 Bench SHALL: set time 23:59:59 in RUN, one tick -> hours=0, minutes=0, seconds=0, digits=16'h0000 (disp_sel=0).
REQ-034 Bench SHALL: mode edge, 3 inc edges from hours=22 -> hours=1, mode=1; mode edge -> mode=2.
REQ-035 Bench SHALL: in SET_MIN hold btn_inc HOLD_CYCLES+2*REPEAT_CYCLES cycles from minutes=58 -> minutes 58->59->0->1->2 (edge + 3 repeats).
REQ-036 Bench SHALL: in SET_HOUR, no buttons for 30 ticks -> mode=0 after 30th tick; seconds unchanged by those ticks.
REQ-037 Bench SHALL: same-cycle btn_mode and btn_inc edges in SET_HOUR at hours=5 -> mode=2, hours=5.
REQ-038 Bench SHALL: in SET_MIN at seconds=42, mode edge -> mode=0, seconds=0; blank=4'b0000.
